// File: rtl/matrix_scan_capture.sv
// Rebuilds an 8x8 LED matrix image from the sampled column/row scan buses and publishes one frame per window.
// Optional: define MATRIX_CAPTURE_DIFF_EN to drive frame_changed from a previous-frame comparison.
module matrix_scan_capture #(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned WINDOW_CYCLES  = 65536,
    parameter bit          ROW_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  col_in,
    input  logic [7:0]  row_in,
    output logic [63:0] frame_out,
    output logic        frame_valid,
    output logic [7:0]  row_hits,
    output logic        overlap_err,
    output logic        frame_changed
);

    localparam int unsigned WIN_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
    localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SETTLE_CYCLES);

    typedef enum logic {ACCUM, PUBLISH} state_t;

    logic [15:0]      sync1_q, sync2_q, samp_q;
    logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
    logic             accept_q, accept_d;
    logic             pat_changed;

    state_t           state_q;
    logic [WIN_W-1:0] win_cnt_q;
    logic [63:0]      acc_q, acc_d;
    logic [7:0]       hit_q, hit_d;
    logic             overlap_q, overlap_d;
    logic [63:0]      frame_q;
    logic [7:0]       row_hits_q;
    logic             frame_valid_q;

    logic [7:0]       pat_col, pat_row, row_sel;

    assign pat_changed = (sync2_q != samp_q);

    always_comb begin
        if (pat_changed) begin
            settle_cnt_d = CNT_W'(1);
        end else if (settle_cnt_q == SETTLE_MAX) begin
            settle_cnt_d = settle_cnt_q;
        end else begin
            settle_cnt_d = settle_cnt_q + CNT_W'(1);
        end
        // A fresh pattern can reach the limit immediately when SETTLE_CYCLES is 1.
        accept_d = (settle_cnt_d == SETTLE_MAX) &&
                   ((settle_cnt_q != SETTLE_MAX) || pat_changed);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            samp_q       <= '0;
            settle_cnt_q <= '0;
            accept_q     <= 1'b0;
        end else begin
            sync1_q      <= {col_in, row_in};
            sync2_q      <= sync1_q;
            samp_q       <= sync2_q;
            settle_cnt_q <= settle_cnt_d;
            accept_q     <= accept_d;
        end
    end

    assign pat_col = samp_q[15:8];
    assign pat_row = samp_q[7:0];
    assign row_sel = ROW_ACTIVE_LOW ? ~pat_row : pat_row;

    // The publish cycle clears the window first, so an accept landing there opens the next frame.
    always_comb begin
        acc_d     = (state_q == PUBLISH) ? '0 : acc_q;
        hit_d     = (state_q == PUBLISH) ? '0 : hit_q;
        overlap_d = overlap_q;
        if (accept_q && (pat_col != 8'h00)) begin
            for (int unsigned r = 0; r < 8; r++) begin
                if (row_sel[r]) begin
                    if (hit_d[r] && (acc_d[r*8 +: 8] != pat_col)) begin
                        overlap_d = 1'b1;
                    end
                    acc_d[r*8 +: 8] = pat_col;
                    hit_d[r]        = 1'b1;
                end
            end
        end
    end

`ifdef MATRIX_CAPTURE_DIFF_EN
    logic frame_changed_q;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ACCUM;
            win_cnt_q     <= '0;
            acc_q         <= '0;
            hit_q         <= '0;
            overlap_q     <= 1'b0;
            frame_q       <= '0;
            row_hits_q    <= '0;
            frame_valid_q <= 1'b0;
`ifdef MATRIX_CAPTURE_DIFF_EN
            frame_changed_q <= 1'b0;
`endif
        end else begin
            acc_q         <= acc_d;
            hit_q         <= hit_d;
            overlap_q     <= overlap_d;
            frame_valid_q <= 1'b0;
`ifdef MATRIX_CAPTURE_DIFF_EN
            frame_changed_q <= 1'b0;
`endif
            case (state_q)
                ACCUM: begin
                    if (win_cnt_q == WIN_LAST) begin
                        state_q <= PUBLISH;
                    end else begin
                        win_cnt_q <= win_cnt_q + WIN_W'(1);
                    end
                end
                PUBLISH: begin
                    frame_q       <= acc_q;
                    row_hits_q    <= hit_q;
                    frame_valid_q <= 1'b1;
                    win_cnt_q     <= '0;
                    state_q       <= ACCUM;
`ifdef MATRIX_CAPTURE_DIFF_EN
                    // frame_q still holds the previously published image here.
                    frame_changed_q <= (acc_q != frame_q);
`endif
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign frame_out   = frame_q;
    assign frame_valid = frame_valid_q;
    assign row_hits    = row_hits_q;
    assign overlap_err = overlap_q;
`ifdef MATRIX_CAPTURE_DIFF_EN
    assign frame_changed = frame_changed_q;
`else
    assign frame_changed = 1'b0;
`endif

endmodule
